// File: rtl/siso_pkg.sv
// Shared types and default parameters for the serial frame controller
// and its shift-register datapath.
package siso_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_GAP   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } frame_state_t;

endpackage

// File: rtl/siso_frame_ctrl_if.sv
// Producer-side handshake and serial-line signals of the frame controller.
// The master modport is the producer/link side; the slave is the controller.
interface siso_frame_ctrl_if #(
    parameter int WIDTH = siso_pkg::DEFAULT_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             hold;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data, hold,
        input  in_ready, serial_out, serial_valid, busy, done
    );

    modport slave (
        input  in_valid, in_data, hold,
        output in_ready, serial_out, serial_valid, busy, done
    );

endinterface

// File: rtl/siso_shifter.sv
// Parallel-load, left-shifting register with zero fill; exposes its MSB.
module siso_shifter #(
    parameter int WIDTH = siso_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= d;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/siso_frame_ctrl.sv
// Frame controller: accepts a parallel word over valid/ready and emits it MSB-first
// on a registered serial line, followed by a programmable idle gap.
module siso_frame_ctrl #(
    parameter int WIDTH = siso_pkg::DEFAULT_WIDTH,
    parameter int GAP   = siso_pkg::DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             reset,
    siso_frame_ctrl_if.slave bus
);

    // The GAP parameter shadows the enum literal of the same name; that literal is package-scoped below.
    import siso_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    frame_state_t  state, state_d;
    logic [CW-1:0] bit_cnt, bit_cnt_d;
    logic          sout_q, sout_d;
    logic          sval_q, sval_d;
    logic          done_q, done_d;
    logic          ready, accept, last_bit;
    logic          gap_start, gap_last;
    logic          sh_load, sh_shift, sh_msb;

    assign last_bit = (bit_cnt == CW'(1));
    assign ready    = (state == IDLE) ||
                      (GAP == 0 && state == SHIFT && last_bit && !bus.hold);
    assign accept   = bus.in_valid && ready;

    // The MSB goes straight to serial_out on load, so the shifter only keeps the remaining bits.
    siso_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .d     ({bus.in_data[WIDTH-2:0], 1'b0}),
        .msb   (sh_msb)
    );

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        sout_d    = sout_q;
        sval_d    = 1'b0;
        done_d    = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        gap_start = 1'b0;

        case (state)
            IDLE: ;
            SHIFT: begin
                if (!bus.hold) begin
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        sout_d    = 1'b0;
                        if (GAP > 0) begin
                            state_d   = siso_pkg::GAP;
                            gap_start = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sout_d    = sh_msb;
                        sval_d    = 1'b1;
                        sh_shift  = 1'b1;
                        bit_cnt_d = bit_cnt - CW'(1);
                        done_d    = (bit_cnt == CW'(2));
                    end
                end
            end
            siso_pkg::GAP: begin
                sout_d = 1'b0;
                if (gap_last) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sout_d  = 1'b0;
            end
        endcase

        // A handshake (from IDLE, or back-to-back on the last bit) overrides the frame end.
        if (accept) begin
            state_d   = SHIFT;
            bit_cnt_d = CW'(WIDTH);
            sout_d    = bus.in_data[WIDTH-1];
            sval_d    = 1'b1;
            done_d    = 1'b0;
            sh_load   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sout_q  <= 1'b0;
            sval_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            sout_q  <= sout_d;
            sval_q  <= sval_d;
            done_q  <= done_d;
        end
    end

    generate
        if (GAP > 0) begin : g_gap
            localparam int GW = $clog2(GAP + 1);
            logic [GW-1:0] gap_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    gap_cnt <= '0;
                end else if (gap_start) begin
                    gap_cnt <= GW'(GAP);
                end else if (state == siso_pkg::GAP && gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - GW'(1);
                end
            end

            assign gap_last = (gap_cnt == GW'(1));
        end else begin : g_no_gap
            assign gap_last = 1'b1;
        end
    endgenerate

    assign bus.in_ready     = ready;
    assign bus.serial_out   = sout_q;
    assign bus.serial_valid = sval_q;
    assign bus.done         = done_q;
    assign bus.busy         = (state != IDLE);

endmodule
